// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - fixed-priority Avalon arbiter for write buffer, dcache and icache fills
// Optional build macro: MEM_ARB_RAW_CHECK_EN (a dcache read that hits the pending write address waits for the write)
module mips_mem_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_req,
  input  logic        wb_full,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_writedata,
  input  logic [3:0]  wb_byteenable,
  output logic        wb_done,
  input  logic        dc_req,
  input  logic [31:0] dc_addr,
  output logic [31:0] dc_rdata,
  output logic        dc_done,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_rdata,
  output logic        ic_done,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        waitrequest,
  input  logic [31:0] mem_readdata
);

  localparam int AW = $clog2(MAX_WAIT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, WRITE, DREAD, IREAD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] age_q, age_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          wb_done_q, wb_done_d;
  logic          dc_done_q, dc_done_d;
  logic          ic_done_q, ic_done_d;
  logic [31:0]   dc_rdata_q, dc_rdata_d;
  logic [31:0]   ic_rdata_q, ic_rdata_d;

  // A port whose done pulse is showing is still dropping its request, so it
  // must not be granted again in that same cycle.
  logic wb_elig, dc_elig, ic_elig, raw_hit, wb_urgent;

  assign wb_elig = wb_req && !wb_done_q;
  assign ic_elig = ic_req && !ic_done_q;
`ifdef MEM_ARB_RAW_CHECK_EN
  // A read of the word the write buffer is about to store would return stale
  // data, so the write goes first.
  assign raw_hit = wb_req && dc_req && (dc_addr[31:2] == wb_addr[31:2]);
  assign dc_elig = dc_req && !dc_done_q && !raw_hit;
`else
  assign raw_hit = 1'b0;
  assign dc_elig = dc_req && !dc_done_q;
`endif
  assign wb_urgent = wb_elig && (wb_full || (age_q == AGE_MAX) || raw_hit);

  // Next-state, grant selection, command capture and completion handling
  always_comb begin
    state_d    = state_q;
    age_d      = age_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    wb_done_d  = 1'b0;
    dc_done_d  = 1'b0;
    ic_done_d  = 1'b0;
    dc_rdata_d = dc_rdata_q;
    ic_rdata_d = ic_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (wb_urgent || (wb_elig && !dc_elig && !ic_elig)) begin
          state_d = WRITE;
          wr_d    = 1'b1;
          addr_d  = wb_addr;
          wdata_d = wb_writedata;
          be_d    = wb_byteenable;
          age_d   = '0;
        end else begin
          if (dc_elig) begin
            state_d = DREAD;
            rd_d    = 1'b1;
            addr_d  = dc_addr;
            wdata_d = '0;
            be_d    = 4'b1111;
          end else if (ic_elig) begin
            state_d = IREAD;
            rd_d    = 1'b1;
            addr_d  = ic_addr;
            wdata_d = '0;
            be_d    = 4'b1111;
          end
          // Reads never age; only a waiting write does.
          if (wb_req && (age_q != AGE_MAX)) begin
            age_d = age_q + AW'(1);
          end
        end
      end
      WRITE: begin
        if (!waitrequest) begin
          state_d   = IDLE;
          wr_d      = 1'b0;
          wb_done_d = 1'b1;
        end
      end
      DREAD: begin
        if (!waitrequest) begin
          state_d    = IDLE;
          rd_d       = 1'b0;
          dc_done_d  = 1'b1;
          dc_rdata_d = mem_readdata;
        end
      end
      IREAD: begin
        if (!waitrequest) begin
          state_d    = IDLE;
          rd_d       = 1'b0;
          ic_done_d  = 1'b1;
          ic_rdata_d = mem_readdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      age_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wb_done_q  <= 1'b0;
      dc_done_q  <= 1'b0;
      ic_done_q  <= 1'b0;
      dc_rdata_q <= '0;
      ic_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      age_q      <= age_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      wb_done_q  <= wb_done_d;
      dc_done_q  <= dc_done_d;
      ic_done_q  <= ic_done_d;
      dc_rdata_q <= dc_rdata_d;
      ic_rdata_q <= ic_rdata_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign wb_done        = wb_done_q;
  assign dc_done        = dc_done_q;
  assign ic_done        = ic_done_q;
  assign dc_rdata       = dc_rdata_q;
  assign ic_rdata       = ic_rdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - directed self-checking bench for mips_mem_arbiter
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_req, wb_full, wb_done;
  logic [31:0] wb_addr, wb_writedata;
  logic [3:0]  wb_byteenable;
  logic        dc_req, dc_done, ic_req, ic_done;
  logic [31:0] dc_addr, dc_rdata, ic_addr, ic_rdata;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, waitrequest;
  logic [3:0]  mem_byteenable;

  int n_checks = 0;
  int n_pass   = 0;
  int nreads;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_full(wb_full), .wb_addr(wb_addr),
    .wb_writedata(wb_writedata), .wb_byteenable(wb_byteenable), .wb_done(wb_done),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_rdata(dc_rdata), .dc_done(dc_done),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_done(ic_done),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .waitrequest(waitrequest), .mem_readdata(mem_readdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads re-request the cycle after their done; the write buffer stays pending.
  task automatic run_until_write(input string tag, output int n);
    bit found;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      dc_req = !dc_done;
      ic_req = !ic_done;
      wb_req = 1'b1;
      if (mem_write) found = 1'b1;
      else if (mem_read) n++;
    end
    check({tag, "_bound"}, 32'(found), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    wb_req = 0; wb_full = 0; wb_addr = 0; wb_writedata = 0; wb_byteenable = 0;
    dc_req = 0; dc_addr = 0; ic_req = 0; ic_addr = 0;
    waitrequest = 0; mem_readdata = 0;

    // Reset state
    tick(); tick();
    check("rst_read", 32'(mem_read), 0);
    check("rst_write", 32'(mem_write), 0);
    check("rst_addr", mem_address, 0);
    check("rst_be", 32'(mem_byteenable), 0);
    check("rst_dones", {29'd0, wb_done, dc_done, ic_done}, 0);
    check("rst_rdata", dc_rdata | ic_rdata, 0);
    rst = 1'b1;
    tick();

    // Reset in the middle of a stalled write
    wb_req = 1; wb_addr = 32'h4000; wb_writedata = 32'hCAFEF00D; wb_byteenable = 4'hF;
    waitrequest = 1;
    tick();
    check("mid_write_up", 32'(mem_write), 1);
    tick();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_write", 32'(mem_write), 0);
    check("mid_rst_addr", mem_address, 0);
    check("mid_rst_wdata", mem_writedata, 0);
    check("mid_rst_done", 32'(wb_done), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    check("mid_rel_idle", 32'(mem_write), 0);
    tick();
    check("mid_reissue", 32'(mem_write), 1);
    check("mid_reissue_addr", mem_address, 32'h4000);
    waitrequest = 0;
    tick();
    check("mid_done", 32'(wb_done), 1);
    wb_req = 0;
    tick();

    // Single write stalled three cycles
    wb_req = 1; wb_addr = 32'h1000; wb_writedata = 32'hDEADBEEF; wb_byteenable = 4'b0011;
    waitrequest = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("wr_held", 32'(mem_write), 1);
      check("wr_addr", mem_address, 32'h1000);
      check("wr_data", mem_writedata, 32'hDEADBEEF);
      check("wr_be", 32'(mem_byteenable), 32'h3);
      check("wr_no_done", 32'(wb_done), 0);
      waitrequest = (i < 3);
      tick();
    end
    check("wr_released", 32'(mem_write), 0);
    check("wr_done", 32'(wb_done), 1);
    wb_req = 0;
    tick();
    check("wr_done_once", 32'(wb_done), 0);

    // Contention between dc and ic
    dc_req = 1; dc_addr = 32'h2000; ic_req = 1; ic_addr = 32'hBFC00000;
    waitrequest = 0; mem_readdata = 32'h11111111;
    tick();
    check("ct_dc_first", {mem_address[31:1], mem_read}, {31'h00001000, 1'b1});
    check("ct_rd_be", 32'(mem_byteenable), 32'hF);
    tick();
    check("ct_gap", 32'(mem_read), 0);
    check("ct_dc_done", 32'(dc_done), 1);
    check("ct_dc_rdata", dc_rdata, 32'h11111111);
    dc_req = 0; mem_readdata = 32'h22222222;
    tick();
    check("ct_ic_read", 32'(mem_read), 1);
    check("ct_ic_addr", mem_address, 32'hBFC00000);
    tick();
    check("ct_ic_done", 32'(ic_done), 1);
    check("ct_ic_rdata", ic_rdata, 32'h22222222);
    check("ct_dc_hold", dc_rdata, 32'h11111111);
    ic_req = 0;
    tick();

    // Starvation: eight reads slip ahead of the write, then aging forces it
    wb_req = 1; wb_addr = 32'h5000; wb_writedata = 32'h12345678; wb_byteenable = 4'hF;
    dc_req = 1; ic_req = 1; mem_readdata = 32'h0;
    run_until_write("st1", nreads);
    check("st1_reads", 32'(nreads), 8);
    check("st1_addr", mem_address, 32'h5000);
    tick();
    check("st1_done", 32'(wb_done), 1);
    wb_req = 0; dc_req = !dc_done; ic_req = !ic_done;
    // Age restarted at 0: the done-cycle read plus eight more
    run_until_write("st2", nreads);
    check("st2_reads", 32'(nreads), 9);
    tick();
    check("st2_done", 32'(wb_done), 1);
    wb_req = 0; dc_req = 0; ic_req = 0;
    tick();
    tick();
    check("st_idle", {30'd0, mem_read, mem_write}, 0);

    // Full write buffer beats a pending read
    wb_req = 1; wb_full = 1; wb_addr = 32'h6000; dc_req = 1; dc_addr = 32'h7000;
    mem_readdata = 32'h33333333;
    tick();
    check("full_write_first", {30'd0, mem_read, mem_write}, 1);
    tick();
    check("full_wb_done", 32'(wb_done), 1);
    wb_req = 0; wb_full = 0;
    tick();
    check("full_then_read", 32'(mem_read), 1);
    check("full_read_addr", mem_address, 32'h7000);
    tick();
    check("full_dc_rdata", dc_rdata, 32'h33333333);
    dc_req = 0;
    tick();

    // Read-after-write to the same word
    wb_req = 1; wb_addr = 32'h3004; wb_writedata = 32'hA5A5A5A5; wb_byteenable = 4'hF;
    dc_req = 1; dc_addr = 32'h3004;
    tick();
`ifdef MEM_ARB_RAW_CHECK_EN
    check("raw_write_first", {30'd0, mem_read, mem_write}, 1);
    mem_readdata = 32'hA5A5A5A5;
    tick();
    check("raw_wb_done", 32'(wb_done), 1);
    wb_req = 0;
    tick();
    check("raw_read_second", {30'd0, mem_read, mem_write}, 2);
    tick();
    check("raw_dc_rdata", dc_rdata, 32'hA5A5A5A5);
    dc_req = 0;
    tick();
`else
    check("raw_read_first", {30'd0, mem_read, mem_write}, 2);
    mem_readdata = 32'h0BADF00D;
    tick();
    check("raw_dc_rdata", dc_rdata, 32'h0BADF00D);
    dc_req = 0;
    tick();
    check("raw_write_second", {30'd0, mem_read, mem_write}, 1);
    tick();
    check("raw_wb_done", 32'(wb_done), 1);
    wb_req = 0;
    tick();
`endif
    check("end_idle", {30'd0, mem_read, mem_write}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
